// File: rtl/prf_wr_arb_pkg.sv
// Shared types and defaults for the integer PRF write-port arbiter.
package prf_wr_arb_pkg;

    // One integer PRF write: result data, physical destination, simulation id.
    typedef struct packed {
        logic [63:0] data;
        logic [6:0]  pdst;
        logic [15:0] simid;
    } t_prf_wr_pkt;

    // Default sizing for prf_wr_arb.
    localparam int PRF_WR_ARB_SKID_DEPTH   = 2;
    localparam int PRF_WR_ARB_STARVE_LIMIT = 4;

    // Completion source identifier, used when logging grants.
    typedef enum logic {
        SRC_EINT = 1'b0,
        SRC_MM   = 1'b1
    } t_prf_wr_src;

endpackage

// File: rtl/prf_wr_skid_fifo.sv
// Small skid FIFO in front of one PRF write source. It has a registered ready,
// a head that is always visible, and a flush that empties it in one cycle.
module prf_wr_skid_fifo
    import prf_wr_arb_pkg::*;
#(
    parameter int  DEPTH = PRF_WR_ARB_SKID_DEPTH,
    parameter type T     = t_prf_wr_pkt,
    parameter int  CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  T                 push_pkt,
    input  logic             pop,
    output T                 head,
    output logic [CNT_W-1:0] count,
    output logic             ready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next pointers, occupancy and ready; flush overrides any push or pop.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
        ready_d = (cnt_d < CNT_W'(DEPTH));
    end

    // Control state register.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
        end
    end

    // Entry storage, written at the tail on push.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; cnt_q alone decides which entries are live.
        if (push) mem_q[wr_ptr_q] <= push_pkt;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = cnt_q;
    assign ready = ready_q;

endmodule

// File: rtl/prf_wr_arb.sv
// Shares the single integer PRF write port between execute (ex1) and memory
// (mm5) completions. Priority is fixed, eint over mm, and a starvation counter
// lets mm win after a run of losses. The winner is registered onto ro0.
module prf_wr_arb
    import prf_wr_arb_pkg::*;
#(
    parameter int SKID_DEPTH   = PRF_WR_ARB_SKID_DEPTH,
    parameter int STARVE_LIMIT = PRF_WR_ARB_STARVE_LIMIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        nuke_valid_rb1,
    input  logic        eint_valid_ex1,
    input  t_prf_wr_pkt eint_pkt_ex1,
    output logic        eint_ready_ex1,
    input  logic        mm_valid_mm5,
    input  t_prf_wr_pkt mm_pkt_mm5,
    output logic        mm_ready_mm5,
    output logic        iprf_wr_valid_ro0,
    output t_prf_wr_pkt iprf_wr_pkt_ro0
);

    localparam int CNT_W = $clog2(SKID_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] eint_cnt, mm_cnt;
    t_prf_wr_pkt      eint_head, mm_head;
    t_prf_wr_pkt      eint_cand_pkt, mm_cand_pkt;
    logic             eint_xfer, eint_has_head, eint_cand, eint_win, eint_push, eint_pop;
    logic             mm_xfer, mm_has_head, mm_cand, mm_win, mm_push, mm_pop;
    logic             mm_force;

    logic             wr_valid_q, wr_valid_d;
    t_prf_wr_pkt      wr_pkt_q, wr_pkt_d;
    logic [STV_W-1:0] starve_cnt_q, starve_cnt_d;

    prf_wr_skid_fifo #(.DEPTH(SKID_DEPTH), .T(t_prf_wr_pkt), .CNT_W(CNT_W)) u_eint_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (nuke_valid_rb1),
        .push     (eint_push),
        .push_pkt (eint_pkt_ex1),
        .pop      (eint_pop),
        .head     (eint_head),
        .count    (eint_cnt),
        .ready    (eint_ready_ex1)
    );

    prf_wr_skid_fifo #(.DEPTH(SKID_DEPTH), .T(t_prf_wr_pkt), .CNT_W(CNT_W)) u_mm_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (nuke_valid_rb1),
        .push     (mm_push),
        .push_pkt (mm_pkt_mm5),
        .pop      (mm_pop),
        .head     (mm_head),
        .count    (mm_cnt),
        .ready    (mm_ready_mm5)
    );

    // Candidates, grant, FIFO push/pop and next output/starvation state.
    always_comb begin
        // A nuke drops same-cycle transfers and suppresses any grant.
        eint_xfer     = eint_valid_ex1 & eint_ready_ex1 & ~nuke_valid_rb1;
        mm_xfer       = mm_valid_mm5 & mm_ready_mm5 & ~nuke_valid_rb1;
        eint_has_head = (eint_cnt != '0);
        mm_has_head   = (mm_cnt != '0);
        eint_cand     = (eint_has_head | eint_xfer) & ~nuke_valid_rb1;
        mm_cand       = (mm_has_head | mm_xfer) & ~nuke_valid_rb1;
        // The head is older than the input, so it goes first; the input bypasses only an empty FIFO.
        eint_cand_pkt = eint_has_head ? eint_head : eint_pkt_ex1;
        mm_cand_pkt   = mm_has_head ? mm_head : mm_pkt_mm5;

        mm_force = (starve_cnt_q == STV_W'(STARVE_LIMIT));
        mm_win   = mm_cand & (~eint_cand | mm_force);
        eint_win = eint_cand & ~mm_win;

        eint_pop  = eint_win & eint_has_head;
        mm_pop    = mm_win & mm_has_head;
        eint_push = eint_xfer & ~(eint_win & ~eint_has_head);
        mm_push   = mm_xfer & ~(mm_win & ~mm_has_head);

        wr_valid_d = eint_win | mm_win;
        wr_pkt_d   = wr_pkt_q;
        if (mm_win) begin
            wr_pkt_d = mm_cand_pkt;
        end else if (eint_win) begin
            wr_pkt_d = eint_cand_pkt;
        end

        starve_cnt_d = '0;
        if (mm_cand & ~mm_win) begin
            starve_cnt_d = mm_force ? starve_cnt_q : starve_cnt_q + STV_W'(1);
        end
    end

    // PRF write register and starvation counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_valid_q   <= 1'b0;
            wr_pkt_q     <= '0;
            starve_cnt_q <= '0;
        end else begin
            wr_valid_q   <= wr_valid_d;
            wr_pkt_q     <= wr_pkt_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign iprf_wr_valid_ro0 = wr_valid_q;
    assign iprf_wr_pkt_ro0   = wr_pkt_q;

    // A source must never present a result while its ready is low.
    eint_valid_needs_ready: assert property (@(posedge clk) disable iff (reset)
        eint_valid_ex1 |-> eint_ready_ex1);
    mm_valid_needs_ready: assert property (@(posedge clk) disable iff (reset)
        mm_valid_mm5 |-> mm_ready_mm5);

endmodule
